// File: rtl/pll_ctrl_pkg.sv
// Shared types for the PLL configuration sequencer and the pll instance it drives.
package pll_ctrl_pkg;

  localparam int PLL_CFG_W = 4;

  typedef logic [PLL_CFG_W-1:0] pll_cfg_t;

  typedef enum logic [2:0] {
    BOOT   = 3'd0,
    IDLE   = 3'd1,
    GATE   = 3'd2,
    LOCK   = 3'd3,
    UNGATE = 3'd4
  } pll_ctrl_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_lock_qual.sv
// Lock qualifier: pll_lock must be seen high on two consecutive samples.
// Also runs the lock timeout, reloaded whenever a new lock wait starts.
// Only instantiated when PLL_LOCK_DETECT_EN is defined.
module pll_lock_qual #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic active_i,
  input  logic pll_lock_i,
  output logic locked_o,
  output logic timeout_o
);

  localparam int                TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0]  TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

  logic             lock_q;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Timeout down-counter: reload on start, count down while a wait is active.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (start_i) begin
      tmo_cnt_d = TMO_LOAD;
    end else if (active_i && (tmo_cnt_q != '0)) begin
      tmo_cnt_d = tmo_cnt_q - 1'b1;
    end
  end

  // Lock history and timer registers; reset covers the boot wait.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      tmo_cnt_q <= TMO_LOAD;
    end else begin
      lock_q    <= pll_lock_i;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign locked_o  = active_i & lock_q & pll_lock_i;
  assign timeout_o = active_i & ~locked_o & (tmo_cnt_q == '0);

endmodule

// File: rtl/pll_cfg_ctrl.sv
// PLL configuration sequencer: gate downstream clock, apply new clk_cfg,
// wait for lock, ungate. Optional lock detect via PLL_LOCK_DETECT_EN;
// without it the lock wait is a fixed LOCK_CYC count and err stays 0.
//
// state  | meaning
// BOOT   | post-reset lock wait on RESET_CFG, clock gated
// IDLE   | accepting requests, clock enabled
// GATE   | clock gated for GATE_CYC cycles before the new code is applied
// LOCK   | new code applied, waiting for lock (or fixed wait after a timeout)
// UNGATE | one-cycle done pulse with the clock re-enabled
module pll_cfg_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int               CFG_W       = PLL_CFG_W,
  parameter logic [CFG_W-1:0] RESET_CFG   = CFG_W'(4'h1),
  parameter int               GATE_CYC    = 4,
  parameter int               LOCK_CYC    = 64,
  parameter int               TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CFG_W-1:0] req_cfg,
  output logic [CFG_W-1:0] pll_cfg,
  input  logic             pll_lock,
  output logic             clk_gate_en,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             err_clr
);

  localparam int               CNT_W     = $clog2(max_int(max_int(LOCK_CYC, TIMEOUT_CYC), GATE_CYC) + 1);
  localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYC - 1);

  pll_ctrl_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CFG_W-1:0] cfg_q, cfg_d, pend_q, pend_d, prev_q, prev_d;
  logic             gate_q, gate_d, done_q, done_d, err_q, err_d, fixed_q, fixed_d;
  logic             lock_ok, tmo, tmo_set, lock_start, lock_active;

  // fixed_q marks the post-timeout LOCK pass, which ignores lock detect.
  assign lock_active = (state_q == BOOT) || ((state_q == LOCK) && !fixed_q);

`ifdef PLL_LOCK_DETECT_EN
  localparam bit DETECT = 1'b1;

  pll_lock_qual #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_lock_qual (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (lock_start),
    .active_i   (lock_active),
    .pll_lock_i (pll_lock),
    .locked_o   (lock_ok),
    .timeout_o  (tmo)
  );
`else
  localparam bit DETECT = 1'b0;

  logic unused_nodet;
  assign lock_ok      = 1'b0;
  assign tmo          = 1'b0;
  assign unused_nodet = pll_lock ^ lock_start ^ lock_active;
`endif

  // Next-state and datapath decisions for the sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cfg_d      = cfg_q;
    pend_d     = pend_q;
    prev_d     = prev_q;
    gate_d     = gate_q;
    done_d     = 1'b0;
    fixed_d    = fixed_q;
    tmo_set    = 1'b0;
    lock_start = 1'b0;
    case (state_q)
      BOOT: begin
        if (DETECT) begin
          if (lock_ok) begin
            state_d = UNGATE;
          end else if (tmo) begin
            tmo_set = 1'b1;
            state_d = UNGATE;
          end
        end else if (cnt_q == LOCK_LAST) begin
          state_d = UNGATE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (req_valid) begin
          pend_d = req_cfg;
          if (req_cfg == cfg_q) begin
            done_d = 1'b1;
          end else begin
            state_d = GATE;
            gate_d  = 1'b0;
            cnt_d   = '0;
          end
        end
      end
      GATE: begin
        if (cnt_q == GATE_LAST) begin
          prev_d     = cfg_q;
          cfg_d      = pend_q;
          state_d    = LOCK;
          cnt_d      = '0;
          lock_start = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOCK: begin
        if (DETECT && !fixed_q) begin
          if (lock_ok) begin
            state_d = UNGATE;
          end else if (tmo) begin
            // Fall back to the last known-good code and give it a fixed wait.
            tmo_set = 1'b1;
            cfg_d   = prev_q;
            fixed_d = 1'b1;
            cnt_d   = '0;
          end
        end else if (cnt_q == LOCK_LAST) begin
          state_d = UNGATE;
          fixed_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      UNGATE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
    if ((state_q != UNGATE) && (state_d == UNGATE)) begin
      gate_d = 1'b1;
      done_d = 1'b1;
      cnt_d  = '0;
    end
    if (tmo_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BOOT;
      cnt_q   <= '0;
      cfg_q   <= RESET_CFG;
      pend_q  <= RESET_CFG;
      prev_q  <= RESET_CFG;
      gate_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      fixed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cfg_q   <= cfg_d;
      pend_q  <= pend_d;
      prev_q  <= prev_d;
      gate_q  <= gate_d;
      done_q  <= done_d;
      err_q   <= err_d;
      fixed_q <= fixed_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign pll_cfg     = cfg_q;
  assign clk_gate_en = gate_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule
